// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types, key map and helper functions for the 4x4
//             matrix keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Key map indexed by {row, col}; entry 0 is row 0 / col 0.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
    localparam logic [15:0][3:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    // Hex code of the key at a given row/column crossing.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

    // Lowest-index row reading low; rows are active-low.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner_if
//  Purpose  : Keypad matrix pins plus the debounced key event outputs.
//             master = scanner side, slave = keypad/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface keypad_scanner_if;

    logic [3:0] rows;       // keypad rows, active-low, asynchronous
    logic [3:0] cols;       // column drive, active-low, one-hot-low
    logic [3:0] key_code;   // last accepted key
    logic       key_valid;  // single-cycle acceptance pulse
    logic       key_held;   // high while accepted key is down

    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface : keypad_scanner_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for asynchronous inputs; resets to
//             all-ones (idle level of pulled-up keypad rows).
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values: shift the input one stage per clock.
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : 4x4 matrix keypad scanner with tick-based debounce of presses
//             and releases; emits one key_valid pulse per accepted press.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_BIT  = 15,
    parameter int DEB_TICKS = 8
) (
    input  wire logic        int_osc,
    input  wire logic        reset,
    input  wire logic [24:0] counter,
    keypad_scanner_if.master kp
);

    localparam logic [3:0] DEB_LIMIT = 4'(DEB_TICKS);

    // Only one counter bit is used; the rest is intentionally ignored.
    logic unused_counter;
    assign unused_counter = ^counter;

    logic       tick_prev_d, tick_prev_q;
    logic       tick;
    logic [3:0] rs;
    state_t     state_d, state_q;
    logic [1:0] col_idx_d, col_idx_q;
    logic [1:0] row_idx_d, row_idx_q;
    logic [3:0] deb_cnt_d, deb_cnt_q;
    logic [3:0] deb_cnt_inc;
    logic [3:0] key_code_d, key_code_q;
    logic       key_valid_d, key_valid_q;
    logic       key_held_d, key_held_q;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (int_osc),
        .rst_n (reset),
        .din   (kp.rows),
        .dout  (rs)
    );

    // Rising edge of the selected counter bit marks a scan tick.
    assign tick_prev_d = counter[TICK_BIT];
    assign tick        = counter[TICK_BIT] & ~tick_prev_q;
    assign deb_cnt_inc = deb_cnt_q + 4'd1;

    // Scan / debounce next-state logic; everything advances only on a tick.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (!(&rs)) begin
                        row_idx_d = first_low_row(rs);
                        deb_cnt_d = 4'd0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!rs[row_idx_q]) begin
                        deb_cnt_d = deb_cnt_inc;
                        if (deb_cnt_inc == DEB_LIMIT) begin
                            state_d     = PRESSED;
                            key_code_d  = key_lookup(row_idx_q, col_idx_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end else begin
                        // Bounce: drop back to scanning, column advances next tick.
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    // Column frozen; only the accepted row is watched (no rollover).
                    if (rs[row_idx_q]) begin
                        deb_cnt_d = 4'd0;
                        state_d   = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rs[row_idx_q]) begin
                        deb_cnt_d = deb_cnt_inc;
                        if (deb_cnt_inc == DEB_LIMIT) begin
                            key_held_d = 1'b0;
                            state_d    = SCAN;
                            col_idx_d  = col_idx_q + 2'd1;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            tick_prev_q <= 1'b0;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_cnt_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            tick_prev_q <= tick_prev_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.cols      = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner (TICK_BIT=2, DEB_TICKS=4).
//             Keypad is modelled as a switch matrix; accepted keys are
//             checked against an expected-event queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    logic        int_osc = 1'b0;
    logic        reset   = 1'b0;
    logic [24:0] counter = '0;
    logic [15:0] press_mask = '0;   // bit r*4+c set = key at row r, col c is down

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    keypad_scanner_if kif();

    keypad_scanner #(
        .TICK_BIT  (2),
        .DEB_TICKS (4)
    ) dut (
        .int_osc (int_osc),
        .reset   (reset),
        .counter (counter),
        .kp      (kif)
    );

    always #5 int_osc = ~int_osc;

    // Upstream counter: held at 0 in reset, otherwise increments each clock.
    initial begin
        forever begin
            @(negedge int_osc);
            if (!reset) counter = '0;
            else        counter = counter + 25'd1;
        end
    end

    // Passive switch matrix: a pressed key pulls its row low when its column is driven low.
    always_comb begin
        kif.rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press_mask[r*4+c] && (kif.cols[c] === 1'b0)) kif.rows[r] = 1'b0;
            end
        end
    end

    // Record every key event the DUT produces.
    always @(negedge int_osc) begin
        if (reset && kif.key_valid === 1'b1) obs_q.push_back(kif.key_code);
    end

    // Advance to just after the next tick edge (counter low bits 3 -> 4).
    task automatic wait_tick();
        int guard;
        guard = 0;
        @(posedge int_osc);
        while (counter[2:0] != 3'd4 && guard < 32) begin
            @(posedge int_osc);
            guard++;
        end
        if (guard >= 32) begin
            tests_run++;
            tests_failed++;
            $display("FAIL tick_timeout: counter=%0h no tick within 32 clocks", counter);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols [4];
        exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        reset = 1'b0;
        press_mask = '0;
        repeat (3) @(posedge int_osc);
        #1;
        tests_run++;
        if (kif.cols !== 4'b1110) begin tests_failed++; $display("FAIL reset_cols: got %b want 1110", kif.cols); end
        tests_run++;
        if (kif.key_code !== 4'h0) begin tests_failed++; $display("FAIL reset_code: got %h want 0", kif.key_code); end
        tests_run++;
        if (kif.key_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", kif.key_valid); end
        tests_run++;
        if (kif.key_held !== 1'b0) begin tests_failed++; $display("FAIL reset_held: got %b want 0", kif.key_held); end
        @(negedge int_osc);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            tests_run++;
            if (kif.cols !== exp_cols[i]) begin
                tests_failed++;
                $display("FAIL idle_cols[%0d]: got %b want %b", i, kif.cols, exp_cols[i]);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL idle_events: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_press_bounce();
        press_mask[5] = 1'b1;                 // '5' at row1/col1
        wait_tick();                          // col0 -> col1
        tests_run++;
        if (kif.cols !== 4'b1101) begin tests_failed++; $display("FAIL bounce_col1: got %b want 1101", kif.cols); end
        wait_tick();                          // detect
        wait_tick();                          // confirm 1
        wait_tick();                          // confirm 2
        press_mask[5] = 1'b0;
        wait_tick();                          // bounce -> back to scan, column holds
        tests_run++;
        if (kif.cols !== 4'b1101) begin tests_failed++; $display("FAIL bounce_hold: got %b want 1101", kif.cols); end
        wait_tick();
        tests_run++;
        if (kif.cols !== 4'b1011) begin tests_failed++; $display("FAIL bounce_resume: got %b want 1011", kif.cols); end
        tests_run++;
        if (kif.key_code !== 4'h0 || kif.key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_outputs: code=%h held=%b want code=0 held=0", kif.key_code, kif.key_held);
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL bounce_events: got %0d want 0", obs_q.size()); end
        wait_tick();                          // col3
        wait_tick();                          // col0
    endtask

    task automatic test_press_5();
        press_mask[5] = 1'b1;
        exp_q.push_back(4'h5);
        wait_tick();                          // col0 -> col1
        wait_tick();                          // detect
        repeat (3) wait_tick();               // confirm 1..3
        tests_run++;
        if (kif.key_valid !== 1'b0 || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL press5_early: valid=%b events=%0d want 0/0", kif.key_valid, obs_q.size());
        end
        wait_tick();                          // confirm 4 -> accept
        tests_run++;
        if (kif.key_valid !== 1'b1) begin tests_failed++; $display("FAIL press5_valid: got %b want 1", kif.key_valid); end
        tests_run++;
        if (kif.key_code !== 4'h5) begin tests_failed++; $display("FAIL press5_code: got %h want 5", kif.key_code); end
        tests_run++;
        if (kif.key_held !== 1'b1) begin tests_failed++; $display("FAIL press5_held: got %b want 1", kif.key_held); end
        @(posedge int_osc);
        #1;
        tests_run++;
        if (kif.key_valid !== 1'b0) begin tests_failed++; $display("FAIL press5_pulse_width: got %b want 0", kif.key_valid); end
        repeat (3) wait_tick();
        tests_run++;
        if (kif.cols !== 4'b1101 || kif.key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL press5_frozen: cols=%b held=%b want 1101/1", kif.cols, kif.key_held);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL press5_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end else begin
            while (exp_q.size() > 0) begin
                logic [3:0] e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin tests_failed++; $display("FAIL press5_event: got %h want %h", o, e); end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_release_bounce();
        press_mask[5] = 1'b0;
        wait_tick();                          // -> release
        wait_tick();                          // release count 1
        press_mask[5] = 1'b1;
        wait_tick();                          // low again -> back to pressed
        tests_run++;
        if (kif.key_held !== 1'b1) begin tests_failed++; $display("FAIL relb_reheld: got %b want 1", kif.key_held); end
        press_mask[5] = 1'b0;
        wait_tick();                          // -> release
        repeat (3) wait_tick();               // count 1..3
        tests_run++;
        if (kif.key_held !== 1'b1 || kif.cols !== 4'b1101) begin
            tests_failed++;
            $display("FAIL relb_early: held=%b cols=%b want 1/1101", kif.key_held, kif.cols);
        end
        wait_tick();                          // count 4 -> released
        tests_run++;
        if (kif.key_held !== 1'b0) begin tests_failed++; $display("FAIL relb_held: got %b want 0", kif.key_held); end
        tests_run++;
        if (kif.cols !== 4'b1011) begin tests_failed++; $display("FAIL relb_cols: got %b want 1011", kif.cols); end
        tests_run++;
        if (kif.key_code !== 4'h5 || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL relb_no_event: code=%h events=%0d want 5/0", kif.key_code, obs_q.size());
        end
    endtask

    task automatic test_priority_rollover();
        wait_tick();                          // col3
        wait_tick();                          // col0
        tests_run++;
        if (kif.cols !== 4'b1110) begin tests_failed++; $display("FAIL prio_col0: got %b want 1110", kif.cols); end
        press_mask = 16'h0101;                // '1' (r0c0) and '7' (r2c0)
        exp_q.push_back(4'h1);
        wait_tick();                          // detect
        repeat (4) wait_tick();               // confirm 1..4
        tests_run++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h1) begin
            tests_failed++;
            $display("FAIL prio_accept: valid=%b code=%h want 1/1", kif.key_valid, kif.key_code);
        end
        press_mask[10] = 1'b1;                // add '9' (r2c2) while '1' held
        repeat (6) wait_tick();
        tests_run++;
        if (kif.cols !== 4'b1110 || kif.key_held !== 1'b1 || kif.key_code !== 4'h1) begin
            tests_failed++;
            $display("FAIL rollover_state: cols=%b held=%b code=%h want 1110/1/1", kif.cols, kif.key_held, kif.key_code);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rollover_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end else begin
            while (exp_q.size() > 0) begin
                logic [3:0] e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin tests_failed++; $display("FAIL rollover_event: got %h want %h", o, e); end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_pressed();
        tests_run++;
        if (kif.key_held !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_held: got %b want 1", kif.key_held); end
        @(posedge int_osc);
        #2 reset = 1'b0;                      // between clock edges
        #1;
        tests_run++;
        if (kif.key_held !== 1'b0) begin tests_failed++; $display("FAIL rmid_held: got %b want 0", kif.key_held); end
        tests_run++;
        if (kif.cols !== 4'b1110) begin tests_failed++; $display("FAIL rmid_cols: got %b want 1110", kif.cols); end
        tests_run++;
        if (kif.key_code !== 4'h0) begin tests_failed++; $display("FAIL rmid_code: got %h want 0", kif.key_code); end
        press_mask = '0;
        @(negedge int_osc);
        #1 reset = 1'b1;
        wait_tick();
        tests_run++;
        if (kif.cols !== 4'b1101) begin tests_failed++; $display("FAIL rmid_restart: got %b want 1101", kif.cols); end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL rmid_events: got %0d want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_press_bounce();
        test_press_5();
        test_release_bounce();
        test_priority_rollover();
        test_reset_mid_pressed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_keypad_scanner
`default_nettype wire
